// File: rtl/hdr_fetch.sv
// Reads the most recently completed HDR frame from the SDRAM double buffer, one
// 128-bit word per req/ack transaction, and pushes each word into the display FIFO.
module hdr_fetch #(
    parameter int unsigned FRAME_WORDS = 38400,
    parameter logic [24:0] BUF0_BASE   = 25'hE1000,
    parameter logic [24:0] BUF1_BASE   = 25'h106800,
    parameter logic [24:0] ADDR_STEP   = 25'd4
) (
    input  logic         clk_133M,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         hdr_last_frame,
    input  logic         ram_busy,
    input  logic         hdr_rd_ack,
    input  logic         rd_data_valid,
    input  logic [127:0] rd_data,
    input  logic         fifo_almost_full,
    output logic         rd_req,
    output logic [24:0]  rd_address,
    output logic         fifo_wr_en,
    output logic [127:0] fifo_data,
    output logic         frame_active,
    output logic         fetch_done,
    output logic         start_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        REQ       = 3'd2,
        WAIT_DATA = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(FRAME_WORDS - 1);

    state_t         state, state_nx;
    logic [15:0]    cnt, cnt_nx;
    logic           rd_req_nx;
    logic [24:0]    rd_address_nx;
    logic           fifo_wr_en_nx;
    logic [127:0]   fifo_data_nx;
    logic           frame_active_nx;
    logic           fetch_done_nx;
    logic           start_err_nx;
    logic           take_word;

    // Next-state and next-output logic; a returned word may complete in the ack cycle.
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        rd_req_nx       = rd_req;
        rd_address_nx   = rd_address;
        fifo_wr_en_nx   = 1'b0;
        fifo_data_nx    = fifo_data;
        frame_active_nx = frame_active;
        fetch_done_nx   = 1'b0;
        take_word       = 1'b0;
        start_err_nx    = start_err | (frame_start & (state != IDLE));

        case (state)
            IDLE: begin
                if (frame_start) begin
                    rd_address_nx   = hdr_last_frame ? BUF1_BASE : BUF0_BASE;
                    cnt_nx          = 16'd0;
                    frame_active_nx = 1'b1;
                    state_nx        = CHECK;
                end else begin
                    state_nx = IDLE;
                end
            end
            CHECK: begin
                if (!fifo_almost_full && !ram_busy) begin
                    rd_req_nx = 1'b1;
                    state_nx  = REQ;
                end else begin
                    state_nx = CHECK;
                end
            end
            REQ: begin
                if (hdr_rd_ack) begin
                    rd_req_nx = 1'b0;
                    state_nx  = WAIT_DATA;
                    take_word = rd_data_valid;
                end else begin
                    state_nx = REQ;
                end
            end
            WAIT_DATA: begin
                take_word = rd_data_valid;
            end
            DONE: begin
                fetch_done_nx   = 1'b1;
                frame_active_nx = 1'b0;
                cnt_nx          = 16'd0;
                state_nx        = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (take_word) begin
            fifo_data_nx  = rd_data;
            fifo_wr_en_nx = 1'b1;
            rd_address_nx = rd_address + ADDR_STEP;
            cnt_nx        = cnt + 16'd1;
            state_nx      = (cnt == LAST_CNT) ? DONE : CHECK;
        end else begin
            fifo_wr_en_nx = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            rd_req       <= 1'b0;
            rd_address   <= 25'd0;
            fifo_wr_en   <= 1'b0;
            fifo_data    <= 128'd0;
            frame_active <= 1'b0;
            fetch_done   <= 1'b0;
            start_err    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            rd_req       <= rd_req_nx;
            rd_address   <= rd_address_nx;
            fifo_wr_en   <= fifo_wr_en_nx;
            fifo_data    <= fifo_data_nx;
            frame_active <= frame_active_nx;
            fetch_done   <= fetch_done_nx;
            start_err    <= start_err_nx;
        end
    end

endmodule

// File: tb/tb_hdr_fetch.sv
// Scoreboard bench for hdr_fetch: a small SDRAM controller model answers requests,
// expected FIFO words are queued at frame start and a monitor checks every push.
module tb_hdr_fetch;

    localparam int          FW   = 4;
    localparam logic [24:0] B0   = 25'hE1000;
    localparam logic [24:0] B1   = 25'h106800;

    logic         clk_133M = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         hdr_last_frame;
    logic         ram_busy;
    logic         hdr_rd_ack;
    logic         rd_data_valid;
    logic [127:0] rd_data;
    logic         fifo_almost_full;
    logic         rd_req;
    logic [24:0]  rd_address;
    logic         fifo_wr_en;
    logic [127:0] fifo_data;
    logic         frame_active;
    logic         fetch_done;
    logic         start_err;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cyc = -10;
    int push_cnt = 0;
    int done_cnt = 0;
    int ack_dly  = 2;
    int data_dly = 3;

    logic [127:0] exp_q[$];
    logic         prev_req   = 1'b0;
    logic         prev_afull = 1'b0;
    logic         prev_busy  = 1'b0;
    logic [24:0]  prev_addr  = 25'd0;

    hdr_fetch #(.FRAME_WORDS(FW)) dut (
        .clk_133M        (clk_133M),
        .rst             (rst),
        .frame_start     (frame_start),
        .hdr_last_frame  (hdr_last_frame),
        .ram_busy        (ram_busy),
        .hdr_rd_ack      (hdr_rd_ack),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .fifo_almost_full(fifo_almost_full),
        .rd_req          (rd_req),
        .rd_address      (rd_address),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data       (fifo_data),
        .frame_active    (frame_active),
        .fetch_done      (fetch_done),
        .start_err       (start_err)
    );

    initial forever #5 clk_133M = ~clk_133M;

    initial forever begin
        @(posedge clk_133M);
        cyc++;
    end

    // Word contents are derived from the address, so a wrong address shows up as wrong data.
    function automatic logic [127:0] data_of(input logic [24:0] a);
        return {7'h11, a, 7'h22, ~a, 7'h33, a ^ 25'h1AAAAAA, 7'h44, a + 25'd1};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_133M);
        #1;
    endtask

    // SDRAM controller model: ack after ack_dly cycles, data data_dly cycles after the ack.
    initial begin : ctrl
        logic [24:0] a;
        forever begin
            tick();
            if (rd_req && !rst) begin
                a = rd_address;
                repeat (ack_dly) tick();
                hdr_rd_ack = 1'b1;
                if (data_dly == 0) begin
                    rd_data_valid = 1'b1;
                    rd_data       = data_of(a);
                    valid_cyc     = cyc;
                end
                tick();
                hdr_rd_ack    = 1'b0;
                rd_data_valid = 1'b0;
                if (data_dly > 0) begin
                    repeat (data_dly - 1) tick();
                    rd_data_valid = 1'b1;
                    rd_data       = data_of(a);
                    valid_cyc     = cyc;
                    tick();
                    rd_data_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pops on each push, plus request gating and address stability.
    initial forever begin
        @(negedge clk_133M);
        if (!rst) begin
            if (fifo_wr_en) begin
                push_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_push: got push of %h, expected none", fifo_data);
                end else begin
                    check("fifo_data", fifo_data, exp_q.pop_front());
                    check("push_latency", 128'(cyc - valid_cyc), 128'd1);
                end
            end
            if (fetch_done) done_cnt++;
            if (rd_req && !prev_req)
                check("req_gate", 128'({prev_afull, prev_busy}), 128'd0);
            if (rd_req && prev_req)
                check("addr_stable", 128'(rd_address), 128'(prev_addr));
        end
        prev_req   = rd_req;
        prev_afull = fifo_almost_full;
        prev_busy  = ram_busy;
        prev_addr  = rd_address;
    end

    task automatic start_frame(input logic buf_sel, input logic [24:0] base);
        hdr_last_frame = buf_sel;
        for (int i = 0; i < FW; i++) exp_q.push_back(data_of(base + 25'(4 * i)));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("frame_active_start", 128'(frame_active), 128'd1);
        check("first_addr", 128'(rd_address), 128'(base));
    endtask

    task automatic wait_pushes(input int n);
        int seen = 0;
        for (int i = 0; i < 500 && seen < n; i++) begin
            tick();
            if (fifo_wr_en) seen++;
        end
        check("push_wait", 128'(seen), 128'(n));
    endtask

    task automatic end_frame(input int p0, input int d0);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (fetch_done) seen = 1'b1;
        end
        check("fetch_done_seen", 128'(seen), 128'd1);
        tick();
        tick();
        check("push_count", 128'(push_cnt - p0), 128'(FW));
        check("done_count", 128'(done_cnt - d0), 128'd1);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        check("frame_active_end", 128'(frame_active), 128'd0);
    endtask

    initial begin : stim
        int p0;
        int d0;
        rst = 1'b1;
        frame_start = 1'b0;
        hdr_last_frame = 1'b0;
        ram_busy = 1'b0;
        hdr_rd_ack = 1'b0;
        rd_data_valid = 1'b0;
        rd_data = 128'd0;
        fifo_almost_full = 1'b0;
        tick();
        tick();
        check("rst_outputs", 128'({rd_req, fifo_wr_en, frame_active, fetch_done, start_err}), 128'd0);
        check("rst_addr", 128'(rd_address), 128'd0);
        check("rst_data", fifo_data, 128'd0);
        rst = 1'b0;
        tick();

        // Buffer 0, ack after 2, data after 3.
        ack_dly = 2; data_dly = 3;
        p0 = push_cnt; d0 = done_cnt;
        start_frame(1'b0, B0);
        end_frame(p0, d0);

        // Buffer 1.
        ack_dly = 0; data_dly = 1;
        p0 = push_cnt; d0 = done_cnt;
        start_frame(1'b1, B1);
        end_frame(p0, d0);

        // Backpressure after word 1: FIFO almost full, then controller busy.
        ack_dly = 1; data_dly = 2;
        p0 = push_cnt; d0 = done_cnt;
        start_frame(1'b1, B1);
        wait_pushes(1);
        fifo_almost_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("req_afull", 128'(rd_req), 128'd0);
        end
        fifo_almost_full = 1'b0;
        ram_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("req_busy", 128'(rd_req), 128'd0);
        end
        ram_busy = 1'b0;
        tick();
        check("req_resume", 128'(rd_req), 128'd1);
        end_frame(p0, d0);

        // Ack and data together on every word.
        ack_dly = 0; data_dly = 0;
        p0 = push_cnt; d0 = done_cnt;
        start_frame(1'b0, B0);
        end_frame(p0, d0);
        check("start_err_clean", 128'(start_err), 128'd0);

        // Mid-frame frame_start and buffer toggle.
        ack_dly = 1; data_dly = 1;
        p0 = push_cnt; d0 = done_cnt;
        start_frame(1'b0, B0);
        wait_pushes(2);
        frame_start = 1'b1;
        hdr_last_frame = 1'b1;
        tick();
        frame_start = 1'b0;
        check("start_err_set", 128'(start_err), 128'd1);
        end_frame(p0, d0);
        check("start_err_sticky", 128'(start_err), 128'd1);

        // Reset while waiting for data; the late data must be ignored.
        ack_dly = 1; data_dly = 6;
        hdr_last_frame = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst_outputs", 128'({rd_req, fifo_wr_en, frame_active, fetch_done, start_err}), 128'd0);
        check("midrst_addr", 128'(rd_address), 128'd0);
        check("midrst_data", fifo_data, 128'd0);
        tick();
        tick();
        rst = 1'b0;
        p0 = push_cnt;
        repeat (12) tick();
        check("late_data_pushes", 128'(push_cnt - p0), 128'd0);
        check("late_data_idle", 128'({rd_req, frame_active}), 128'd0);

        ack_dly = 2; data_dly = 3;
        p0 = push_cnt; d0 = done_cnt;
        start_frame(1'b0, B0);
        end_frame(p0, d0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
